instr_fetch: RTL and testbench

//   Instruction-fetch front end for the RISC-V core: owns the fetch PC, issues word reads to instruction

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN / ILEN       : address and instruction widths
//   RV_NOP            : canonical RISC-V no-op (addi x0, x0, 0)
//   DEFAULT_RESET_PC  : default first fetch address
//   fetch_entry_t     : one prefetch buffer entry {pc, instr}
//   align_word()      : clears the byte-offset bits of an address
package instr_fetch_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam int unsigned     ILEN             = 32;
  localparam logic [ILEN-1:0] RV_NOP           = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush.
//   clk, rst : clock, asynchronous active-high reset (clears storage too)
//   flush    : empties the FIFO (count and pointers to 0); overrides push/pop
//   push     : write wdata at the tail (ignored when full)
//   pop      : drop the head entry (ignored when empty)
//   wdata    : entry to write
//   rdata    : head entry (no bypass: a push is visible from the next edge)
//   count    : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push = push && (count < CW'(DEPTH));
    do_pop  = pop && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues one word read at a
// time to instruction memory and buffers returned words for decode.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req/addr   : read request (held until ack) and word address
//   imem_ack/rdata  : request completion and returned instruction word
//   instr_valid/ready, instr, instr_pc : decode-side valid/ready head
//   redirect_valid/pc : taken branch/jump; flushes and retargets fetch
//   PC              : current fetch PC (debug)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] PC
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic [XLEN-1:0] addr_q;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            load_addr;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign imem_req    = (state == ST_FETCH) || (state == ST_DROP);
  assign imem_addr   = addr_q;
  assign PC          = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  always_comb begin
    pop      = instr_valid && instr_ready;
    // A word returned in the same cycle as a redirect is on the wrong path.
    push     = (state == ST_FETCH) && imem_ack && !redirect_valid;
    wr_entry = '{pc: fetch_pc, instr: imem_rdata};

    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) fetch_pc_nxt = align_word(redirect_pc);
    else if (push)      fetch_pc_nxt = fetch_pc + 32'd4;

    state_nxt = state;
    case (state)
      ST_START: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (redirect_valid)
          state_nxt = imem_ack ? ST_FETCH : ST_DROP;
        else if (push && !pop && (count == CW'(FIFO_DEPTH - 1)))
          state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (redirect_valid || (count < CW'(FIFO_DEPTH))) state_nxt = ST_FETCH;
      end
      ST_DROP: begin
        if (imem_ack) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_START;
    endcase

    // The address only moves between requests, so it stays stable while
    // imem_req is high; it always picks up the latest (possibly redirected) PC.
    load_addr = (imem_req && imem_ack) ||
                ((state_nxt == ST_FETCH) && (state != ST_FETCH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_START;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (load_addr) addr_q <= fetch_pc_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch. Memory returns ~addr.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] PC;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .PC             (PC)
  );

  assign imem_rdata = ~imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge, releases it; state is START afterwards.
  task automatic do_reset(input logic ack, input logic rdy);
    rst = 1'b1;
    imem_ack = ack;
    instr_ready = rdy;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_pc",    PC,                   32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_ipc",   instr_pc,             32'h0);

    // 1: zero-wait memory, decode always ready -> one instruction per cycle
    do_reset(1'b1, 1'b1);
    step();
    chk("t1_req",   {31'd0, imem_req},    32'd1);
    chk("t1_addr0", imem_addr,            32'h0);
    chk("t1_val0",  {31'd0, instr_valid}, 32'd0);
    step();
    chk("t1_val1",  {31'd0, instr_valid}, 32'd1);
    chk("t1_ipc0",  instr_pc,             32'h0);
    chk("t1_ins0",  instr,                32'hFFFF_FFFF);
    chk("t1_addr1", imem_addr,            32'h4);
    step();
    chk("t1_ipc1",  instr_pc,             32'h4);
    chk("t1_addr2", imem_addr,            32'h8);
    step();
    chk("t1_ipc2",  instr_pc,             32'h8);
    chk("t1_ins2",  instr,                32'hFFFF_FFF7);
    chk("t1_addr3", imem_addr,            32'hC);

    // 2: decode stalled -> fill to 4, stop, then drain in order and resume
    do_reset(1'b1, 1'b0);
    step();
    step();
    step();
    step();
    chk("t2_cnt3_req", {31'd0, imem_req}, 32'd1);
    chk("t2_cnt3_addr", imem_addr,        32'hC);
    step();
    chk("t2_full_req", {31'd0, imem_req}, 32'd0);
    chk("t2_full_pc",  PC,                32'h10);
    chk("t2_head0",    instr_pc,          32'h0);
    step();
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    instr_ready = 1'b1;
    step();
    chk("t2_head1",    instr_pc,          32'h4);
    chk("t2_still_full", {31'd0, imem_req}, 32'd0);
    step();
    chk("t2_head2",    instr_pc,          32'h8);
    chk("t2_resume_req", {31'd0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr,      32'h10);
    step();
    chk("t2_head3",    instr_pc,          32'hC);
    step();
    chk("t2_head4",    instr_pc,          32'h10);
    step();
    chk("t2_head5",    instr_pc,          32'h14);

    // 3: redirect while 0x8 is pending, ack arrives late -> DROP
    do_reset(1'b1, 1'b0);
    step();
    step();
    step();
    chk("t3_pend_addr", imem_addr, 32'h8);
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("t3_drop_req",  {31'd0, imem_req},    32'd1);
    chk("t3_drop_addr", imem_addr,            32'h8);
    chk("t3_drop_val",  {31'd0, instr_valid}, 32'd0);
    chk("t3_drop_pc",   PC,                   32'h100);
    step();
    chk("t3_wait_addr", imem_addr,            32'h8);
    step();
    imem_ack = 1'b1;
    step();
    chk("t3_new_addr",  imem_addr,            32'h100);
    chk("t3_new_val",   {31'd0, instr_valid}, 32'd0);
    step();
    chk("t3_first_val", {31'd0, instr_valid}, 32'd1);
    chk("t3_first_ipc", instr_pc,             32'h100);
    chk("t3_first_ins", instr,                32'hFFFF_FEFF);

    // 4: redirect + ack + pop together with two words buffered
    do_reset(1'b1, 1'b0);
    step();
    step();
    step();
    chk("t4_pre_val", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("t4_val",  {31'd0, instr_valid}, 32'd0);
    chk("t4_addr", imem_addr,            32'h200);
    chk("t4_req",  {31'd0, imem_req},    32'd1);
    step();
    chk("t4_ipc",  instr_pc,             32'h200);

    // 5: address wrap and target alignment
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap_addr", imem_addr, 32'h0);
    chk("t5_wrap_ipc",  instr_pc,  32'hFFFF_FFFC);
    chk("t5_wrap_pc",   PC,        32'h0);
    step();
    chk("t5_zero_ipc",  instr_pc,  32'h0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    chk("t5_align_addr", imem_addr, 32'h100);
    chk("t5_align_pc",   PC,        32'h100);

    // 6: asynchronous reset while in DROP
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk("t6_drop_req", {31'd0, imem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_req", {31'd0, imem_req},    32'd0);
    chk("t6_async_val", {31'd0, instr_valid}, 32'd0);
    chk("t6_async_addr", imem_addr,           32'h0);
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("t6_start_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("t6_fetch_req",  {31'd0, imem_req}, 32'd1);
    chk("t6_fetch_addr", imem_addr,         32'h0);
    step();
    chk("t6_first_ipc", instr_pc,             32'h0);
    chk("t6_first_val", {31'd0, instr_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
